gate_barrier_ctrl: RTL and testbench
====================================

# gate_barrier_ctrl

Per-gate barrier actuator controller, one instance on the entry lane and one on the exit lane. It sits directly downstream of the garage occupancy controller and consumes that block's level-type door command, `Open_entry_door` or `Open_exit_door`. It drives the barrier motor up and down against limit switches and holds the barrier open until the car has cleared the loop sensor. It reports car passage and motor faults back to the system.

## Interface
- `MOVE_TIMEOUT`, default 200: maximum cycles allowed in RAISING or LOWERING before FAULT.
- `WAIT_TIME`, default 1000: cycles the barrier stays OPEN with no car detected before closing.
- `HOLD_TIME`, default 100: cycles `Car_present` must stay low after passage before lowering.
- `TMR_W`, default 16: timer width; every time parameter must be ≤ 2^TMR_W − 1.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: reset, asynchronous and active-high.
- `Open_cmd` in 1: door command level from the garage controller; only its rising edge is used.
- `Up_limit` in 1: barrier fully-up switch, active-high.
- `Down_limit` in 1: barrier fully-down switch, active-high.
- `Car_present` in 1: vehicle loop under the barrier, active-high.
- `Motor_up` out 1: raise the barrier.
- `Motor_down` out 1: lower the barrier.
- `Gate_open` out 1: high in OPEN and HOLD.
- `Car_passed` out 1: one-cycle pulse per car cleared.
- `Fault` out 1: sticky fault indicator.

## Operation
- All inputs are treated as already synchronized.
- `open_rise` = `Open_cmd` & ~`open_d`, where `open_d` is `Open_cmd` registered. `open_d` resets to 0.
- FSM states: CLOSED, RAISING, OPEN, HOLD, LOWERING, FAULT. Reset state is CLOSED.
- Global rule, every state except FAULT: `Up_limit` & `Down_limit` → FAULT. This has the highest priority.
- CLOSED: motors off. `open_rise` → RAISING. `Car_present` is ignored.
- RAISING: `Motor_up`=1. Priority order:
  - `Up_limit` → OPEN.
  - Timer = MOVE_TIMEOUT−1 → FAULT.
- OPEN: `Gate_open`=1. Internal flag `car_seen` is cleared on entry and set by `Car_present`=1. Priority order:
  - `car_seen` & ~`Car_present` → HOLD, and pulse `Car_passed`.
  - ~`car_seen` & ~`Car_present` & timer = WAIT_TIME−1 → LOWERING.
  - The timer counts only while `car_seen`=0.
- HOLD: `Gate_open`=1. `Car_present`=1 clears the timer and stays in HOLD. Timer = HOLD_TIME−1 with `Car_present`=0 → LOWERING.
- LOWERING: `Motor_down`=1. Priority order:
  - `Car_present` | `open_rise` → RAISING (safety reversal / next car).
  - `Down_limit` → CLOSED.
  - Timer = MOVE_TIMEOUT−1 → FAULT.
- FAULT: both motors 0, `Fault`=1, all inputs ignored. Exit only through `Reset`.
- `Open_cmd` edges in RAISING, OPEN and HOLD are ignored and not queued.
- Timer: TMR_W-bit, cleared on every state transition (including LOWERING→RAISING), otherwise +1 per cycle. It saturates at all-ones and never wraps.
- `Motor_up` and `Motor_down` are never high together, by construction.

## Timing
- Reset values: `Motor_up`=0, `Motor_down`=0, `Gate_open`=0, `Car_passed`=0, `Fault`=0, state CLOSED, timer 0, `car_seen`=0, `open_d`=0.
- Asynchronous assertion takes effect immediately. Release is sampled at the next `Clk` edge.
- Reset mid-motion drops both motors in the same instant.
- `Motor_up`, `Motor_down`, `Gate_open` and `Fault` decode only from the state register (Moore), so they are glitch-free.
- `Car_passed` is a registered pulse, exactly one cycle, coincident with the first HOLD cycle.
- Latency: `Open_cmd` rises before edge k → `Motor_up`=1 in cycle k+1. All other transitions take effect one cycle after the sampling edge.
- Maximum motor-on time per move is MOVE_TIMEOUT cycles. FAULT is entered on edge MOVE_TIMEOUT after move entry.
- Limit and timeout asserted in the same cycle: the limit wins.

## Test plan
Parameters for all scenarios: MOVE_TIMEOUT=8, WAIT_TIME=20, HOLD_TIME=4.

1. Normal cycle: `Open_cmd` 0→1; `Up_limit` at cycle 3; `Car_present` 1 for 5 cycles then 0.
   - Required: `Motor_up` high cycles 1–3; `Gate_open`=1; one `Car_passed` pulse.
   - Required: `Motor_down` starts 4 cycles after `Car_present` falls; `Down_limit` → CLOSED, all outputs 0.
2. No car: open as in scenario 1, never assert `Car_present`.
   - Required: LOWERING exactly 20 cycles after OPEN entry; `Car_passed` never pulses.
3. Safety reversal: `Car_present`=1 during LOWERING.
   - Required: `Motor_down`→0 and `Motor_up`→1 next cycle; no `Car_passed` pulse until the loop clears from the following OPEN.
4. Motor timeout: hold `Up_limit`=0 in RAISING.
   - Required: `Motor_up` high exactly 8 cycles, then `Fault`=1 and motors 0.
   - Required: `Open_cmd` toggles are ignored; only `Reset` clears `Fault`.
5. Level command: hold `Open_cmd`=1 across a full cycle.
   - Required: the gate closes and stays CLOSED; a new 0→1 edge reopens it.
   - Required: `Up_limit` & `Down_limit` both 1 in CLOSED → FAULT next cycle.
6. Asynchronous reset asserted mid-RAISING, between clock edges.
   - Required: `Motor_up` drops immediately; after release, state is CLOSED and all outputs are 0.

Source files
------------

// File: rtl/gate_barrier_ctrl.sv
`default_nettype none
// =============================================================================
// gate_barrier_ctrl : limit-switch barrier actuator for one garage lane
// Rev 1.0
// =============================================================================
module gate_barrier_ctrl #(
   parameter int MOVE_TIMEOUT = 200,
   parameter int WAIT_TIME    = 1000,
   parameter int HOLD_TIME    = 100,
   parameter int TMR_W        = 16
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Open_cmd,
   input  logic Up_limit,
   input  logic Down_limit,
   input  logic Car_present,
   output logic Motor_up,
   output logic Motor_down,
   output logic Gate_open,
   output logic Car_passed,
   output logic Fault
);

   typedef enum logic [2:0] {
      ST_CLOSED   = 3'd0,
      ST_RAISING  = 3'd1,
      ST_OPEN     = 3'd2,
      ST_HOLD     = 3'd3,
      ST_LOWERING = 3'd4,
      ST_FAULT    = 3'd5
   } state_t;

   localparam logic [TMR_W-1:0] MOVE_LAST = TMR_W'(MOVE_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_TIME - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_TIME - 1);

   state_t           state;
   state_t           state_next;
   logic [TMR_W-1:0] timer;
   logic             open_d;
   logic             car_seen;
   logic             pass_pulse;
   logic             open_rise;

   assign open_rise = Open_cmd & ~open_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= ST_CLOSED;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_CLOSED: begin
            if (open_rise) state_next = ST_RAISING;
         end
         ST_RAISING: begin
            if (Up_limit)                state_next = ST_OPEN;
            else if (timer == MOVE_LAST) state_next = ST_FAULT;
         end
         ST_OPEN: begin
            if (car_seen && !Car_present)
               state_next = ST_HOLD;
            else if (!car_seen && !Car_present && timer == WAIT_LAST)
               state_next = ST_LOWERING;
         end
         ST_HOLD: begin
            if (!Car_present && timer == HOLD_LAST) state_next = ST_LOWERING;
         end
         ST_LOWERING: begin
            // a car on the loop or a fresh command reverses the barrier
            if (Car_present || open_rise) state_next = ST_RAISING;
            else if (Down_limit)          state_next = ST_CLOSED;
            else if (timer == MOVE_LAST)  state_next = ST_FAULT;
         end
         ST_FAULT: begin
            state_next = ST_FAULT;
         end
         default: begin
            state_next = ST_FAULT;
         end
      endcase
      // contradictory limit switches override everything outside FAULT
      if (state != ST_FAULT && Up_limit && Down_limit) state_next = ST_FAULT;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         timer      <= '0;
         open_d     <= 1'b0;
         car_seen   <= 1'b0;
         pass_pulse <= 1'b0;
      end else begin
         open_d     <= Open_cmd;
         pass_pulse <= (state == ST_OPEN) && (state_next == ST_HOLD);
         car_seen   <= (state == ST_OPEN) && (state_next == ST_OPEN) && (car_seen || Car_present);
         if (state_next != state)
            timer <= '0;
         else if (state == ST_HOLD && Car_present)
            timer <= '0;
         else if (state == ST_OPEN && car_seen)
            timer <= timer;
         else if (timer != {TMR_W{1'b1}})
            timer <= timer + TMR_W'(1);
      end
   end

   assign Motor_up   = (state == ST_RAISING);
   assign Motor_down = (state == ST_LOWERING);
   assign Gate_open  = (state == ST_OPEN) || (state == ST_HOLD);
   assign Fault      = (state == ST_FAULT);
   assign Car_passed = pass_pulse;

endmodule
`default_nettype wire

// File: tb/tb_gate_barrier_ctrl.sv
`default_nettype none
// =============================================================================
// tb_gate_barrier_ctrl : scoreboard bench with a phase/counter reference model
// Rev 1.0
// =============================================================================
module tb_gate_barrier_ctrl;

   localparam int MOVE_TIMEOUT = 8;
   localparam int WAIT_TIME    = 20;
   localparam int HOLD_TIME    = 4;
   localparam int TMR_W        = 16;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   logic Open_cmd = 1'b0;
   logic Up_limit = 1'b0;
   logic Down_limit = 1'b0;
   logic Car_present = 1'b0;
   logic Motor_up, Motor_down, Gate_open, Car_passed, Fault;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   gate_barrier_ctrl #(
      .MOVE_TIMEOUT(MOVE_TIMEOUT),
      .WAIT_TIME   (WAIT_TIME),
      .HOLD_TIME   (HOLD_TIME),
      .TMR_W       (TMR_W)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Open_cmd   (Open_cmd),
      .Up_limit   (Up_limit),
      .Down_limit (Down_limit),
      .Car_present(Car_present),
      .Motor_up   (Motor_up),
      .Motor_down (Motor_down),
      .Gate_open  (Gate_open),
      .Car_passed (Car_passed),
      .Fault      (Fault)
   );

   always #5 Clk = ~Clk;

   typedef enum int {M_CLOSED, M_RAISING, M_OPEN, M_HOLD, M_LOWERING, M_FAULT} phase_t;

   // dwell: cycles spent in the phase (idle cycles only, for OPEN); quiet: loop-clear cycles in HOLD
   typedef struct {
      phase_t phase;
      int     dwell;
      int     quiet;
      bit     seen;
      bit     prev_open;
      bit     pass;
   } mstate_t;

   mstate_t m = '{M_CLOSED, 0, 0, 1'b0, 1'b0, 1'b0};
   logic [4:0] exp_q[$];

   function automatic mstate_t model_step(mstate_t s, bit o, bit u, bit d, bit c);
      mstate_t n = s;
      bit rise = o && !s.prev_open;
      n.prev_open = o;
      n.pass = 1'b0;
      if (s.phase != M_FAULT && u && d) begin
         n.phase = M_FAULT;
      end else begin
         case (s.phase)
            M_CLOSED:   if (rise) n.phase = M_RAISING;
            M_RAISING:  if (u) n.phase = M_OPEN;
                        else if (s.dwell + 1 >= MOVE_TIMEOUT) n.phase = M_FAULT;
            M_OPEN:     if (s.seen && !c) begin n.phase = M_HOLD; n.pass = 1'b1; end
                        else if (!s.seen && !c && s.dwell + 1 >= WAIT_TIME) n.phase = M_LOWERING;
            M_HOLD:     if (!c && s.quiet + 1 >= HOLD_TIME) n.phase = M_LOWERING;
            M_LOWERING: if (c || rise) n.phase = M_RAISING;
                        else if (d) n.phase = M_CLOSED;
                        else if (s.dwell + 1 >= MOVE_TIMEOUT) n.phase = M_FAULT;
            default:    n.phase = s.phase;
         endcase
      end
      if (n.phase != s.phase) begin
         n.dwell = 0;
         n.quiet = 0;
         n.seen  = 1'b0;
      end else begin
         n.dwell = s.seen ? s.dwell : s.dwell + 1;
         n.quiet = c ? 0 : s.quiet + 1;
         n.seen  = s.seen || (s.phase == M_OPEN && c);
      end
      return n;
   endfunction

   function automatic logic [4:0] expect_vec(mstate_t s);
      return {s.phase == M_RAISING, s.phase == M_LOWERING,
              (s.phase == M_OPEN || s.phase == M_HOLD), s.pass, s.phase == M_FAULT};
   endfunction

   // reference model: advances on every edge and queues the expected outputs
   initial forever begin
      @(posedge Clk);
      if (Reset) m = '{M_CLOSED, 0, 0, 1'b0, 1'b0, 1'b0};
      else       m = model_step(m, Open_cmd, Up_limit, Down_limit, Car_present);
      exp_q.push_back(expect_vec(m));
   end

   // monitor: compares the DUT outputs against the queued expectation
   initial forever begin
      logic [4:0] e;
      logic [4:0] a;
      @(posedge Clk);
      #1;
      a = {Motor_up, Motor_down, Gate_open, Car_passed, Fault};
      if (Car_passed) pulses++;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty t=%0t act=%b", $time, a);
      end else begin
         e = exp_q.pop_front();
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t act=%b exp=%b (up,down,open,passed,fault)", $time, a, e);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input bit o, input bit u, input bit d, input bit c);
      @(negedge Clk);
      Open_cmd = o; Up_limit = u; Down_limit = d; Car_present = c;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1; Open_cmd = 1'b0; Up_limit = 1'b0; Down_limit = 1'b0; Car_present = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int p0;
      int car_rate;
      int up_rate;
      bit o, u, d, c;

      #1 Reset = 1'b1;
      #1 chk("reset_state", {Motor_up, Motor_down, Gate_open, Car_passed, Fault}, 0);
      @(negedge Clk);
      Reset = 1'b0;

      // normal cycle, then level command held across the whole cycle
      p0 = pulses;
      tick(1, 0, 0, 0);
      chk("open_latency", Motor_up, 1);
      tick(1, 0, 0, 0);
      tick(1, 1, 0, 0);
      chk("gate_open", Gate_open, 1);
      repeat (5) tick(1, 0, 0, 1);
      tick(1, 0, 0, 0);
      chk("car_passed_pulse", Car_passed, 1);
      n = 0;
      while (!Motor_down && n < 40) begin tick(1, 0, 0, 0); n++; end
      chk("hold_to_lower", n, HOLD_TIME);
      tick(1, 0, 1, 0);
      chk("closed_outputs", {Motor_up, Motor_down, Gate_open, Car_passed, Fault}, 0);
      chk("one_pulse", pulses - p0, 1);
      repeat (3) tick(1, 0, 0, 0);
      chk("level_cmd_stays_closed", Motor_up, 0);
      tick(0, 0, 0, 0);
      tick(1, 0, 0, 0);
      chk("new_edge_reopens", Motor_up, 1);

      // no car: wait timer closes the gate
      do_reset();
      p0 = pulses;
      tick(1, 0, 0, 0);
      tick(1, 1, 0, 0);
      n = 0;
      while (!Motor_down && n < 60) begin tick(1, 0, 0, 0); n++; end
      chk("wait_time", n, WAIT_TIME);
      chk("no_pulse", pulses - p0, 0);

      // safety reversal during lowering
      tick(1, 0, 0, 1);
      chk("reversal", {Motor_up, Motor_down}, 2);
      tick(1, 1, 0, 1);
      chk("reversal_pulses", pulses - p0, 0);
      tick(1, 0, 0, 1);
      tick(1, 0, 0, 0);
      chk("reversal_pass", Car_passed, 1);

      // motor timeout while raising, commands ignored in fault
      do_reset();
      tick(1, 0, 0, 0);
      n = 0;
      while (Motor_up && n < 40) begin n++; tick(n[0], 0, 0, 0); end
      chk("raise_timeout", n, MOVE_TIMEOUT);
      chk("fault_set", {Motor_up, Motor_down, Fault}, 1);
      for (int i = 0; i < 6; i++) tick(i[0], 0, 0, 0);
      chk("fault_sticky", {Motor_up, Fault}, 1);
      do_reset();
      chk("fault_cleared", Fault, 0);

      // both limits in CLOSED
      tick(0, 1, 1, 0);
      chk("both_limits_fault", Fault, 1);

      // asynchronous reset mid-raise
      do_reset();
      tick(1, 0, 0, 0);
      chk("raising_before_reset", Motor_up, 1);
      @(negedge Clk);
      #2 Reset = 1'b1;
      #1 chk("async_reset_drop", {Motor_up, Motor_down}, 0);
      Open_cmd = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
      tick(0, 0, 0, 0);
      chk("after_reset", {Motor_up, Motor_down, Gate_open, Car_passed, Fault}, 0);

      // randomized episodes, reactive to the model's phase
      for (int ep = 0; ep < 25; ep++) begin
         do_reset();
         car_rate = $urandom_range(2, 40);
         up_rate  = $urandom_range(2, 10);
         for (int k = 0; k < 160; k++) begin
            o = Open_cmd;
            if ($urandom_range(0, 7) == 0) o = ~o;
            u = (m.phase == M_RAISING) && ($urandom_range(0, up_rate - 1) == 0);
            d = ((m.phase == M_LOWERING) && ($urandom_range(0, 3) == 0)) ||
                ((m.phase == M_CLOSED) && ($urandom_range(0, 1) == 1));
            c = ($urandom_range(0, car_rate - 1) == 0);
            if (m.phase == M_HOLD || m.phase == M_OPEN) c = c || ($urandom_range(0, 3) == 0 && Car_present);
            if ($urandom_range(0, 299) == 0) begin u = 1; d = 1; end
            tick(o, u, d, c);
         end
      end

      @(negedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
